// File: rtl/core_seq_pkg.sv
// Shared types for the core run sequencer: FSM states, result status codes,
// and a helper for the host-owned phases.
package core_seq_pkg;

    localparam int unsigned STATUS_W = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        RUN    = 3'd2,
        ABORT  = 3'd3,
        REPORT = 3'd4
    } seq_state_e;

    typedef enum logic [STATUS_W-1:0] {
        ST_OK      = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_ABORT   = 2'b10,
        ST_BADPROG = 2'b11
    } run_status_e;

    // The host may own data memory only while the core is guaranteed idle.
    function automatic logic is_host_phase(input seq_state_e st);
        return (st == IDLE) || (st == REPORT);
    endfunction

endpackage

// File: rtl/run_timer.sv
// Clear/enable saturating cycle counter with a terminal-count compare against
// a selectable limit; tc_c flags the cycle whose increment reaches the limit.
module run_timer #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [CW-1:0] limit_i,
    output logic [CW-1:0] inc_count_c,
    output logic          tc_c
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] count_q;

    assign inc_count_c = (count_q == CNT_MAX) ? count_q : count_q + CW'(1);
    assign tc_c        = en_i && (inc_count_c == limit_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= inc_count_c;
        end
    end

endmodule

// File: rtl/core_run_sequencer.sv
// Host-facing run sequencer for the single-cycle core: start pulse, done/timeout/
// abort handling, cycle count reporting and host data-memory arbitration.
module core_run_sequencer
    import core_seq_pkg::*;
#(
    parameter int unsigned CW        = 16,
    parameter int unsigned PW        = 2,
    parameter int unsigned NPROG     = 3,
    parameter int unsigned START_CYC = 2,
    parameter int unsigned TIMEOUT   = 4000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                host_req,
    input  logic [PW-1:0]       host_prog,
    input  logic                host_abort,
    output logic                busy,
    output logic                core_start,
    output logic                core_reset,
    input  logic                core_done,
    output logic [PW-1:0]       prog_sel,
    output logic                res_valid,
    input  logic                res_ack,
    output logic [STATUS_W-1:0] res_status,
    output logic [CW-1:0]       res_cycles,
    input  logic                hmem_req,
    output logic                hmem_gnt
);

    localparam logic [CW-1:0] START_LIMIT = CW'(START_CYC);
    localparam logic [CW-1:0] RUN_LIMIT   = CW'(TIMEOUT);
    localparam logic [PW:0]   NPROG_LIM   = (PW+1)'(NPROG);

    seq_state_e    state_q;
    logic          prog_ok_c;
    logic          tmr_clr_c;
    logic          tmr_en_c;
    logic [CW-1:0] tmr_limit_c;
    logic [CW-1:0] tmr_inc_c;
    logic          tmr_tc_c;

    assign prog_ok_c = ({1'b0, host_prog} < NPROG_LIM);

    // One timer serves both phases: start-pulse length, then RUN cycles/watchdog.
    assign tmr_en_c    = (state_q == START) || (state_q == RUN);
    assign tmr_limit_c = (state_q == START) ? START_LIMIT : RUN_LIMIT;
    assign tmr_clr_c   = (state_q == IDLE) || ((state_q == START) && tmr_tc_c);

    run_timer #(
        .CW (CW)
    ) u_run_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr_i       (tmr_clr_c),
        .en_i        (tmr_en_c),
        .limit_i     (tmr_limit_c),
        .inc_count_c (tmr_inc_c),
        .tc_c        (tmr_tc_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            core_start <= 1'b0;
            core_reset <= 1'b0;
            prog_sel   <= '0;
            res_valid  <= 1'b0;
            res_status <= '0;
            res_cycles <= '0;
            hmem_gnt   <= 1'b0;
        end else begin
            hmem_gnt   <= hmem_req && is_host_phase(state_q);
            core_reset <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (host_req) begin
                        busy <= 1'b1;
                        if (prog_ok_c) begin
                            state_q    <= START;
                            prog_sel   <= host_prog;
                            core_start <= 1'b1;
                            hmem_gnt   <= 1'b0;
                        end else begin
                            state_q    <= REPORT;
                            res_status <= ST_BADPROG;
                            res_cycles <= '0;
                            res_valid  <= 1'b1;
                        end
                    end
                end
                START: begin
                    if (host_abort) begin
                        state_q    <= ABORT;
                        core_start <= 1'b0;
                        core_reset <= 1'b1;
                        res_status <= ST_ABORT;
                        res_cycles <= '0;
                    end else if (tmr_tc_c) begin
                        state_q    <= RUN;
                        core_start <= 1'b0;
                    end
                end
                RUN: begin
                    // done beats the watchdog, which beats a host abort
                    if (core_done) begin
                        state_q    <= REPORT;
                        res_status <= ST_OK;
                        res_cycles <= tmr_inc_c;
                        res_valid  <= 1'b1;
                        hmem_gnt   <= hmem_req;
                    end else if (tmr_tc_c) begin
                        state_q    <= ABORT;
                        core_reset <= 1'b1;
                        res_status <= ST_TIMEOUT;
                        res_cycles <= tmr_inc_c;
                    end else if (host_abort) begin
                        state_q    <= ABORT;
                        core_reset <= 1'b1;
                        res_status <= ST_ABORT;
                        res_cycles <= tmr_inc_c;
                    end
                end
                ABORT: begin
                    state_q   <= REPORT;
                    res_valid <= 1'b1;
                    hmem_gnt  <= hmem_req;
                end
                REPORT: begin
                    if (res_ack) begin
                        state_q   <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_run_sequencer.sv
// Randomized scoreboard bench for core_run_sequencer: the driver pushes expected
// results from a rule-level model, a monitor checks per-cycle phase outputs and results.
module tb_core_run_sequencer;

    localparam int unsigned CW = 16;
    localparam int unsigned PW = 2;
    localparam int NPROG = 3;
    localparam int SC    = 2;
    localparam int TO    = 120;

    localparam int P_IDLE = 0, P_START = 1, P_RUN = 2, P_ABORT = 3, P_REPORT = 4;
    localparam int ST_OK = 0, ST_TO = 1, ST_AB = 2, ST_BAD = 3;

    typedef struct {
        int st;
        int cyc;
        int prog;
        bit good;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          host_req;
    logic [PW-1:0] host_prog;
    logic          host_abort;
    logic          busy;
    logic          core_start;
    logic          core_reset;
    logic          core_done;
    logic [PW-1:0] prog_sel;
    logic          res_valid;
    logic          res_ack;
    logic [1:0]    res_status;
    logic [CW-1:0] res_cycles;
    logic          hmem_req;
    logic          hmem_gnt;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t cur_exp;
    int   phase = P_IDLE;
    int   cur_prog = 0;
    bit   mon_en = 0;
    bit   hreq_force = 0;
    bit   req_prev = 0;
    bit   valid_prev = 0;

    core_run_sequencer #(
        .CW        (CW),
        .PW        (PW),
        .NPROG     (NPROG),
        .START_CYC (SC),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .host_req   (host_req),
        .host_prog  (host_prog),
        .host_abort (host_abort),
        .busy       (busy),
        .core_start (core_start),
        .core_reset (core_reset),
        .core_done  (core_done),
        .prog_sel   (prog_sel),
        .res_valid  (res_valid),
        .res_ack    (res_ack),
        .res_status (res_status),
        .res_cycles (res_cycles),
        .hmem_req   (hmem_req),
        .hmem_gnt   (hmem_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Result of one run from the rules: earliest event wins, ties resolved done > timeout > abort.
    function automatic exp_t model(input int prog, input int d, input int a, input bit a_start);
        exp_t r;
        r.prog = prog;
        r.good = (prog < NPROG);
        if (!r.good) begin
            r.st = ST_BAD; r.cyc = 0;
        end else if (a_start) begin
            r.st = ST_AB; r.cyc = 0;
        end else begin
            r.st = ST_TO; r.cyc = TO;
            if (d > 0 && d <= r.cyc) begin r.st = ST_OK; r.cyc = d; end
            if (a > 0 && a < r.cyc)  begin r.st = ST_AB; r.cyc = a; end
        end
        return r;
    endfunction

    // Host data-memory request: random, sticky-ish, or forced high.
    initial begin
        hmem_req = 1'b0;
        forever begin
            @(negedge clk);
            if (hreq_force) hmem_req = 1'b1;
            else if (($urandom % 4) == 0) hmem_req = ~hmem_req;
        end
    end

    // Monitor: per-cycle phase outputs plus scoreboard pop on each new result.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                chk("busy", busy, phase != P_IDLE);
                chk("core_start", core_start, phase == P_START);
                chk("core_reset", core_reset, phase == P_ABORT);
                chk("res_valid", res_valid, phase == P_REPORT);
                chk("hmem_gnt", hmem_gnt, req_prev && (phase == P_IDLE || phase == P_REPORT));
                if (phase == P_START || phase == P_RUN || phase == P_ABORT)
                    chk("prog_sel_stable", prog_sel, cur_prog);
                if (res_valid && !valid_prev) begin
                    chk("result_expected", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        cur_exp = sb_q.pop_front();
                        chk("res_status", res_status, cur_exp.st);
                        chk("res_cycles", res_cycles, cur_exp.cyc);
                        if (cur_exp.good) chk("prog_sel", prog_sel, cur_exp.prog);
                    end
                end else if (res_valid) begin
                    chk("res_status_held", res_status, cur_exp.st);
                    chk("res_cycles_held", res_cycles, cur_exp.cyc);
                end
            end
            req_prev   = hmem_req;
            valid_prev = res_valid;
        end
    end

    // One complete transaction, entered and left at a negedge in IDLE.
    task automatic run_one(input int prog, input int d, input int a, input bit a_start);
        exp_t e;
        e = model(prog, d, a, a_start);
        repeat ($urandom_range(0, 2)) begin
            host_req = 1'b0; res_ack = 1'($urandom); host_abort = 1'($urandom);
            core_done = 1'($urandom);
            @(negedge clk);
        end
        host_req = 1'b1; host_prog = PW'(prog);
        res_ack = 1'($urandom); host_abort = 1'($urandom); core_done = 1'($urandom);
        sb_q.push_back(e);
        @(negedge clk);
        host_req = 1'($urandom);
        if (!e.good) begin
            phase = P_REPORT;
        end else begin
            cur_prog = prog;
            if (a_start) begin
                phase = P_START; host_abort = 1'b1; core_done = 1'($urandom);
                @(negedge clk);
                host_abort = 1'b0; core_done = 1'b0; phase = P_ABORT;
                @(negedge clk);
            end else begin
                for (int j = 0; j < SC; j++) begin
                    phase = P_START; host_abort = 1'b0;
                    core_done = 1'($urandom); res_ack = 1'($urandom);
                    @(negedge clk);
                end
                phase = P_RUN;
                for (int k = 1; k <= e.cyc; k++) begin
                    core_done = (k == d); host_abort = (k == a);
                    res_ack = 1'($urandom); host_req = 1'($urandom);
                    @(negedge clk);
                end
                core_done = 1'b0; host_abort = 1'b0;
                if (e.st != ST_OK) begin
                    phase = P_ABORT; host_abort = 1'($urandom);
                    @(negedge clk);
                    host_abort = 1'b0;
                end
            end
            phase = P_REPORT;
        end
        res_ack = 1'b0;
        repeat ($urandom_range(0, 3)) begin
            host_req = 1'($urandom); host_abort = 1'($urandom);
            @(negedge clk);
        end
        res_ack = 1'b1; host_abort = 1'b0;
        @(negedge clk);
        res_ack = 1'b0; host_req = 1'b0; phase = P_IDLE;
    endtask

    initial begin
        reset_n = 1'b1; host_req = 1'b0; host_prog = '0; host_abort = 1'b0;
        core_done = 1'b0; res_ack = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_core_start", core_start, 0);
        chk("reset_core_reset", core_reset, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_hmem_gnt", hmem_gnt, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        hreq_force = 1'b1;
        run_one(1, 100, 0, 1'b0);
        hreq_force = 1'b0;
        run_one(3, 5, 0, 1'b0);
        run_one(0, 0, 0, 1'b0);
        run_one(2, 20, 20, 1'b0);
        run_one(1, 0, 10, 1'b0);
        run_one(0, TO, 0, 1'b0);
        run_one(2, 1, 0, 1'b0);
        run_one(2, 0, 0, 1'b1);
        run_one(1, 0, TO, 1'b0);

        // Asynchronous reset in the middle of RUN with a non-zero prior result held.
        host_req = 1'b1; host_prog = PW'(1); core_done = 1'b0; host_abort = 1'b0;
        @(negedge clk);
        host_req = 1'b0; cur_prog = 1;
        for (int j = 0; j < SC; j++) begin
            phase = P_START;
            @(negedge clk);
        end
        phase = P_RUN;
        repeat (57) @(negedge clk);
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_reset", core_reset, 0);
        chk("rst_prog_sel", prog_sel, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_status", res_status, 0);
        chk("rst_res_cycles", res_cycles, 0);
        chk("rst_hmem_gnt", hmem_gnt, 0);
        phase = P_IDLE;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        run_one(0, 7, 0, 1'b0);
        for (int n = 0; n < 60; n++) begin
            int p, d, a;
            bit s;
            p = int'($urandom_range(0, 3));
            d = (($urandom % 4) == 0) ? 0 : int'($urandom_range(1, TO + 20));
            a = (($urandom % 2) == 0) ? 0 : int'($urandom_range(1, TO + 20));
            s = (($urandom % 16) == 0);
            run_one(p, d, a, s);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
